mask_denoise_stream: RTL and testbench

- Streaming 3x3 spatial denoiser for the binary colour-classification mask.
- Sits between the HSV classifier and the bounding-box tracker. Consumes a raw 1-bit mask in raster order through a valid/ready handshake.
- Emits the filtered mask as out_img with matching row/col coordinates, plus a one-cycle V_sync pulse after each complete frame.
- Produces exactly the stream the tracker consumes: out_img, row, col, V_sync.

---
 rtl/mask_denoise_stream.sv | 152 +++++++++++++++
 tb/tb_mask_denoise_stream.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mask_denoise_stream.sv
// Streaming 3x3 threshold filter for a 1-bit raster mask. Two line buffers feed a
// 3-column window; synthetic zero feeds pad the right edge and the bottom row.
module mask_denoise_stream #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int THRESH = 5,
  parameter int CW     = 13
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_pix,
  input  logic          in_sof,
  output logic          out_valid,
  output logic          out_img,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          V_sync
);
  localparam int KW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(HEIGHT + 1);
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);
  localparam logic [KW-1:0] K_END  = KW'(WIDTH);
  localparam logic [RW-1:0] R_LAST = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] R_END  = RW'(HEIGHT);
  localparam logic [3:0]    THR    = 4'(THRESH);

  // state   | meaning
  // S_RUN   | accepting pixels of the current line
  // S_EOL   | zero feed at k=WIDTH closing a line
  // S_FLUSH | zero row r=HEIGHT, k=0..WIDTH, draining the last line
  // S_VSYNC | frame complete, V_sync follows next cycle
  typedef enum logic [1:0] {S_RUN, S_EOL, S_FLUSH, S_VSYNC} state_t;

  state_t        state, state_nx;
  logic [RW-1:0] r, r_nx, r_f;
  logic [KW-1:0] k, k_nx, k_f;
  logic [8:0]    win, win_nx;
  logic [WIDTH:0] lb0, lb1;
  logic          accept, feed, real_feed, emit;
  logic [2:0]    col_in;
  logic [3:0]    cnt;

  assign accept = in_valid & in_ready;

  always_comb begin
    state_nx  = state;
    r_nx      = r;
    k_nx      = k;
    r_f       = r;
    k_f       = k;
    feed      = 1'b0;
    real_feed = 1'b0;
    case (state)
      S_RUN: begin
        if (accept) begin
          feed      = 1'b1;
          real_feed = 1'b1;
          // a start-of-frame pixel re-anchors the frame wherever we were
          if (in_sof) begin
            r_f = '0;
            k_f = '0;
          end
          r_nx = r_f;
          if (k_f == K_LAST) begin
            k_nx     = K_END;
            state_nx = S_EOL;
          end else begin
            k_nx = k_f + KW'(1);
          end
        end
      end
      S_EOL: begin
        feed = 1'b1;
        k_nx = '0;
        if (r == R_LAST) begin
          r_nx     = R_END;
          state_nx = S_FLUSH;
        end else begin
          r_nx     = r + RW'(1);
          state_nx = S_RUN;
        end
      end
      S_FLUSH: begin
        feed = 1'b1;
        if (k == K_END) begin
          k_nx     = '0;
          r_nx     = '0;
          state_nx = S_VSYNC;
        end else begin
          k_nx = k + KW'(1);
        end
      end
      default: begin
        r_nx     = '0;
        k_nx     = '0;
        state_nx = S_RUN;
      end
    endcase
  end

  always_comb begin
    col_in = 3'b000;
    if (k_f != K_END) begin
      col_in[2] = (r_f >= RW'(2)) ? lb1[k_f] : 1'b0;
      col_in[1] = (r_f != '0) ? lb0[k_f] : 1'b0;
    end
    col_in[0] = real_feed & in_pix;
    win_nx = (k_f == '0) ? {6'b0, col_in} : {win[5:0], col_in};
    cnt = '0;
    for (int i = 0; i < 9; i++) cnt = cnt + 4'(win_nx[i]);
    emit = feed && (r_f != '0) && (k_f != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_RUN;
      r         <= '0;
      k         <= '0;
      win       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_img   <= 1'b0;
      row       <= '0;
      col       <= '0;
      V_sync    <= 1'b0;
    end else begin
      state     <= state_nx;
      r         <= r_nx;
      k         <= k_nx;
      if (feed) win <= win_nx;
      in_ready  <= (state_nx == S_RUN);
      out_valid <= emit;
      out_img   <= emit && (cnt >= THR);
      if (emit) begin
        row <= CW'(r_f - RW'(1));
        col <= CW'(k_f - KW'(1));
      end
      V_sync    <= (state == S_VSYNC);
    end
  end

  // line buffers hold no frame state worth resetting
  always_ff @(posedge clk) begin
    if (real_feed) begin
      lb1[k_f] <= lb0[k_f];
      lb0[k_f] <= in_pix;
    end
  end

endmodule

// File: tb/tb_mask_denoise_stream.sv
// Bench for mask_denoise_stream: two instances (THRESH 5 and 9) run in lockstep
// against a neighbourhood-count model of each frame.
module tb_mask_denoise_stream;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int CW = 13;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, in_pix = 1'b0, in_sof = 1'b0;
  logic rdy5, ov5, oi5, vs5, rdy9, ov9, oi9, vs9;
  logic [CW-1:0] row5, col5, row9, col9;

  int checks = 0, errors = 0;
  int pcyc = 0;

  bit frame [H][W];
  bit exp5[$], exp9[$], pre5[$], pre9[$], seq_ref[$];
  int q5_row[$], q5_col[$], q5_cyc[$], q9_row[$], q9_col[$];
  bit q5_img[$], q9_img[$];
  int vs_cyc[$];
  int vs9_n = 0, vs_overlap = 0, idle_bad = 0;
  bit rdy_at [int];
  int acc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) pcyc++;

  mask_denoise_stream #(.WIDTH(W), .HEIGHT(H), .THRESH(5), .CW(CW)) dut5 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy5), .in_pix(in_pix),
    .in_sof(in_sof), .out_valid(ov5), .out_img(oi5), .row(row5), .col(col5), .V_sync(vs5));

  mask_denoise_stream #(.WIDTH(W), .HEIGHT(H), .THRESH(9), .CW(CW)) dut9 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy9), .in_pix(in_pix),
    .in_sof(in_sof), .out_valid(ov9), .out_img(oi9), .row(row9), .col(col9), .V_sync(vs9));

  always @(negedge clk) begin
    rdy_at[pcyc] = rdy5 & rdy9;
    if (ov5) begin
      q5_row.push_back(int'(row5)); q5_col.push_back(int'(col5));
      q5_img.push_back(oi5); q5_cyc.push_back(pcyc);
    end
    if (ov9) begin
      q9_row.push_back(int'(row9)); q9_col.push_back(int'(col9)); q9_img.push_back(oi9);
    end
    if ((!ov5 && oi5) || (!ov9 && oi9)) idle_bad++;
    if (vs5) begin
      vs_cyc.push_back(pcyc);
      if (ov5) vs_overlap++;
    end
    if (vs9) vs9_n++;
  end

  task automatic clear_queues();
    q5_row.delete(); q5_col.delete(); q5_cyc.delete(); q5_img.delete();
    q9_row.delete(); q9_col.delete(); q9_img.delete();
    vs_cyc.delete(); acc_q.delete();
    vs9_n = 0; vs_overlap = 0;
  endtask

  // Expected output: count of set pixels among in-frame 3x3 neighbours.
  task automatic build_exp();
    exp5.delete(); exp9.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        int n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
              n += int'(frame[r + dr][c + dc]);
        exp5.push_back(n >= 5);
        exp9.push_back(n >= 9);
      end
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frame[r][c] = bit'($urandom_range(1));
  endtask

  task automatic send_pixels(input int npix, input int gap_pct);
    for (int p = 0; p < npix; p++) begin
      bit acc = 0;
      int budget = 0;
      while (!acc) begin
        @(negedge clk);
        in_valid = ($urandom_range(99) >= gap_pct);
        in_pix   = frame[p / W][p % W];
        in_sof   = (p == 0);
        acc = in_valid && rdy5;
        if (acc) acc_q.push_back(pcyc);
        budget++;
        if (!acc && budget > 300) begin
          checks++; errors++;
          $display("FAIL send_timeout: pixel %0d not accepted in %0d cycles", p, budget);
          in_valid = 0;
          return;
        end
      end
    end
    @(negedge clk);
    in_valid = 0; in_sof = 0; in_pix = 0;
  endtask

  task automatic wait_vsync(input string name);
    int n = 0;
    while (vs_cyc.size() == 0 && n < 200) begin @(negedge clk); n++; end
    if (vs_cyc.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_vsync_timeout: no V_sync after %0d cycles, need one", name, n);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    #2 reset = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ov5, oi5, vs5, rdy5} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl5: got %b need 0000", {ov5, oi5, vs5, rdy5});
    end
    checks++;
    if (row5 !== '0 || col5 !== '0) begin
      errors++; $display("FAIL reset_coord: got (%0d,%0d) need (0,0)", row5, col5);
    end
    checks++;
    if ({ov9, oi9, vs9, rdy9} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl9: got %b need 0000", {ov9, oi9, vs9, rdy9});
    end
    reset = 1;
    @(negedge clk);
    checks++;
    if (rdy5 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b need 1", rdy5); end
  endtask

  task automatic test_single_dot();
    clear_queues();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame[r][c] = 0;
    frame[1][2] = 1;
    build_exp();
    send_pixels(W * H, 0);
    wait_vsync("dot");
    checks++;
    if (q5_row.size() != W * H || q9_row.size() != W * H) begin
      errors++; $display("FAIL dot_count: got %0d/%0d need %0d", q5_row.size(), q9_row.size(), W * H);
    end
    for (int i = 0; i < W * H && i < q5_row.size() && i < q9_row.size(); i++) begin
      checks++;
      if (q5_row[i] != i / W || q5_col[i] != i % W || q5_img[i] !== exp5[i] ||
          q9_row[i] != i / W || q9_col[i] != i % W || q9_img[i] !== exp9[i]) begin
        errors++;
        $display("FAIL dot_pix%0d: got (%0d,%0d)=%0d/%0d need (%0d,%0d)=%0d/%0d", i,
                 q5_row[i], q5_col[i], q5_img[i], q9_img[i], i / W, i % W, exp5[i], exp9[i]);
      end
    end
    checks++;
    if (vs_cyc.size() != 1 || vs9_n != 1) begin
      errors++; $display("FAIL dot_vsync_n: got %0d/%0d need 1", vs_cyc.size(), vs9_n);
    end
    if (vs_cyc.size() > 0 && q5_cyc.size() > 0) begin
      checks++;
      if (vs_cyc[0] != q5_cyc[$] + 1) begin
        errors++; $display("FAIL dot_vsync_pos: got cycle %0d need %0d", vs_cyc[0], q5_cyc[$] + 1);
      end
    end
    checks++;
    if (vs_overlap != 0 || idle_bad != 0) begin
      errors++; $display("FAIL dot_idle: got overlap %0d idle_img %0d need 0 0", vs_overlap, idle_bad);
    end
  endtask

  task automatic test_all_ones();
    int ones9 = 0, low = 0, last;
    clear_queues();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame[r][c] = 1;
    build_exp();
    send_pixels(W * H, 0);
    wait_vsync("ones");
    checks++;
    if (q5_img.size() != W * H || q9_img.size() != W * H) begin
      errors++; $display("FAIL ones_count: got %0d/%0d need %0d", q5_img.size(), q9_img.size(), W * H);
    end
    for (int i = 0; i < W * H && i < q5_img.size() && i < q9_img.size(); i++) begin
      checks++;
      if (q5_img[i] !== exp5[i] || q9_img[i] !== exp9[i] || q5_row[i] != i / W || q5_col[i] != i % W) begin
        errors++;
        $display("FAIL ones_pix%0d: got (%0d,%0d)=%0d/%0d need %0d/%0d", i, q5_row[i], q5_col[i],
                 q5_img[i], q9_img[i], exp5[i], exp9[i]);
      end
      ones9 += int'(q9_img[i]);
    end
    if (q5_img.size() > 0) begin
      checks++;
      if (q5_img[0] !== 1'b0) begin errors++; $display("FAIL ones_corner: got %0d need 0", q5_img[0]); end
    end
    checks++;
    if (ones9 != (H - 2) * (W - 2)) begin
      errors++; $display("FAIL ones_erode: got %0d ones need %0d", ones9, (H - 2) * (W - 2));
    end
    for (int p = 1; p < acc_q.size(); p++) begin
      int need = (p % W == 0) ? 2 : 1;
      checks++;
      if (acc_q[p] - acc_q[p - 1] != need) begin
        errors++; $display("FAIL ready_gap%0d: got %0d need %0d", p, acc_q[p] - acc_q[p - 1], need);
      end
    end
    if (acc_q.size() > 0) begin
      last = acc_q[$];
      for (int c = last + 1; c <= last + 11; c++) if (rdy_at.exists(c) && !rdy_at[c]) low++;
      checks++;
      if (low != 11 || !rdy_at.exists(last + 12) || !rdy_at[last + 12]) begin
        errors++; $display("FAIL ready_tail: got %0d low cycles need 11 then high", low);
      end
    end
  endtask

  task automatic test_back_to_back_gaps();
    clear_queues();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame[r][c] = (r <= 2 && c >= 3 && c <= 5);
    build_exp();
    send_pixels(W * H, 0);
    wait_vsync("solid");
    seq_ref = q5_img;
    clear_queues();
    send_pixels(W * H, 30);
    wait_vsync("gaps");
    checks++;
    if (q5_img.size() != W * H || seq_ref.size() != W * H) begin
      errors++; $display("FAIL gaps_count: got %0d/%0d need %0d", q5_img.size(), seq_ref.size(), W * H);
    end
    for (int i = 0; i < W * H && i < q5_img.size() && i < seq_ref.size(); i++) begin
      checks++;
      if (q5_img[i] !== exp5[i] || seq_ref[i] !== exp5[i] || q5_row[i] != i / W || q5_col[i] != i % W) begin
        errors++;
        $display("FAIL gaps_pix%0d: got gap %0d nogap %0d at (%0d,%0d) need %0d", i, q5_img[i],
                 seq_ref[i], q5_row[i], q5_col[i], exp5[i]);
      end
    end
    checks++;
    if (vs_cyc.size() != 1) begin errors++; $display("FAIL gaps_vsync_n: got %0d need 1", vs_cyc.size()); end
  endtask

  task automatic test_reset_mid_frame();
    clear_queues();
    fill_random();
    send_pixels(2 * W + 3, 0);
    reset = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ov5, vs5, rdy5, oi5} !== 4'b0000) begin
      errors++; $display("FAIL midreset_outs: got %b need 0000", {ov5, vs5, rdy5, oi5});
    end
    clear_queues();
    reset = 1;
    @(negedge clk);
    fill_random();
    build_exp();
    send_pixels(W * H, 0);
    wait_vsync("midreset");
    checks++;
    if (q5_img.size() != W * H || vs_cyc.size() != 1) begin
      errors++; $display("FAIL midreset_count: got %0d outs %0d vsync need %0d 1", q5_img.size(), vs_cyc.size(), W * H);
    end
    for (int i = 0; i < W * H && i < q5_img.size() && i < q9_img.size(); i++) begin
      checks++;
      if (q5_img[i] !== exp5[i] || q9_img[i] !== exp9[i] || q5_row[i] != i / W || q5_col[i] != i % W) begin
        errors++;
        $display("FAIL midreset_pix%0d: got (%0d,%0d)=%0d/%0d need %0d/%0d", i, q5_row[i], q5_col[i],
                 q5_img[i], q9_img[i], exp5[i], exp9[i]);
      end
    end
  endtask

  task automatic test_sof_restart();
    int npre = W + 3;
    clear_queues();
    fill_random();
    build_exp();
    pre5.delete(); pre9.delete();
    for (int i = 0; i < npre; i++) begin pre5.push_back(exp5[i]); pre9.push_back(exp9[i]); end
    send_pixels(2 * W + 4, 0);
    fill_random();
    build_exp();
    send_pixels(W * H, 0);
    wait_vsync("sof");
    checks++;
    if (q5_img.size() != npre + W * H || vs_cyc.size() != 1) begin
      errors++; $display("FAIL sof_count: got %0d outs %0d vsync need %0d 1", q5_img.size(), vs_cyc.size(), npre + W * H);
    end
    for (int i = 0; i < npre + W * H && i < q5_img.size() && i < q9_img.size(); i++) begin
      int j = (i < npre) ? i : i - npre;
      bit e5 = (i < npre) ? pre5[i] : exp5[j];
      bit e9 = (i < npre) ? pre9[i] : exp9[j];
      checks++;
      if (q5_img[i] !== e5 || q9_img[i] !== e9 || q5_row[i] != j / W || q5_col[i] != j % W) begin
        errors++;
        $display("FAIL sof_pix%0d: got (%0d,%0d)=%0d/%0d need (%0d,%0d)=%0d/%0d", i, q5_row[i],
                 q5_col[i], q5_img[i], q9_img[i], j / W, j % W, e5, e9);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_dot();
    test_all_ones();
    test_back_to_back_gaps();
    test_reset_mid_frame();
    test_sof_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
